// File: rtl/analog_io_sequencer.sv
// analog_io_sequencer: Wishbone-configurable pad-mode controller for the
// analog user pads. Each pad is set independently to hi-Z, digital out or
// analog. A mode change is break-before-make: every pad whose mode changes is
// held hi-Z for GUARD_CYCLES clocks before its new mode is applied.
// Optional feature macro: ANALOG_IO_SEQ_IRQ_EN (implements irq and CTRL.IRQ_EN;
// when undefined irq is tied low and CTRL bit1 reads 0).
module analog_io_sequencer #(
  parameter int unsigned NUM_PADS     = 6,
  parameter int unsigned GUARD_CYCLES = 16,
  parameter logic [31:0] BASE_ADDR    = 32'h3000_0000
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                wbs_cyc_i,
  input  logic                wbs_stb_i,
  input  logic                wbs_we_i,
  input  logic [3:0]          wbs_sel_i,
  input  logic [31:0]         wbs_adr_i,
  input  logic [31:0]         wbs_dat_i,
  output logic                wbs_ack_o,
  output logic [31:0]         wbs_dat_o,
  output logic [NUM_PADS-1:0] pad_oeb,
  output logic [NUM_PADS-1:0] pad_out,
  output logic [NUM_PADS-1:0] ana_en,
  output logic                busy,
  output logic                irq
);

  localparam int unsigned MW = 2 * NUM_PADS;
  localparam int unsigned CW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(GUARD_CYCLES - 1);

  localparam logic [2:0] IDX_CTRL     = 3'd0;
  localparam logic [2:0] IDX_MODE_REQ = 3'd1;
  localparam logic [2:0] IDX_OUT      = 3'd2;
  localparam logic [2:0] IDX_MODE_CUR = 3'd3;
  localparam logic [2:0] IDX_STATUS   = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_GUARD,
    S_MAKE
  } state_t;

  // Software-visible registers
  logic                ctrl_en;
  logic                ctrl_irq_en;
  logic [MW-1:0]       mode_req;
  logic [NUM_PADS-1:0] out_reg;
  logic [MW-1:0]       mode_cur;
  logic                done;

  // Sequencer state
  state_t              state;
  logic [CW-1:0]       cnt;
  logic [MW-1:0]       mode_pend;
  logic [NUM_PADS-1:0] chg;

  // Bus decode
  logic        wb_req;
  logic        wb_wr;
  logic [31:0] offset;
  logic        in_range;
  logic [2:0]  idx;
  logic [31:0] rdata;

  // Next-state values
  logic                nxt_en;
  logic                nxt_irq_en;
  logic [MW-1:0]       nxt_mode_req;
  logic [NUM_PADS-1:0] nxt_out_reg;
  logic                clr_done;
  logic [31:0]         wr_ctrl32;
  logic [31:0]         wr_mode32;
  logic [31:0]         wr_out32;

  state_t              nxt_state;
  logic [CW-1:0]       nxt_cnt;
  logic [MW-1:0]       nxt_cur;
  logic [MW-1:0]       nxt_pend;
  logic [NUM_PADS-1:0] nxt_chg;
  logic [NUM_PADS-1:0] diff_mask;
  logic                set_done;
  logic                nxt_done;

  logic [NUM_PADS-1:0] nxt_oeb;
  logic [NUM_PADS-1:0] nxt_pad_out;
  logic [NUM_PADS-1:0] nxt_ana;

  logic unused_bits;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  sel);
    logic [31:0] res;
    for (int unsigned b = 0; b < 4; b++) begin
      res[8*b +: 8] = sel[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
    end
    return res;
  endfunction

  // Bus request qualification and register address decode
  always_comb begin
    wb_req   = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
    wb_wr    = wb_req & wbs_we_i;
    offset   = wbs_adr_i - BASE_ADDR;
    in_range = (offset[31:5] == '0);
    idx      = in_range ? offset[4:2] : 3'd7;
  end

  // Read data mux; unmapped locations read zero
  always_comb begin
    rdata = '0;
    unique case (idx)
      IDX_CTRL:     rdata = {30'd0, ctrl_irq_en, ctrl_en};
      IDX_MODE_REQ: rdata = 32'(mode_req);
      IDX_OUT:      rdata = 32'(out_reg);
      IDX_MODE_CUR: rdata = 32'(mode_cur);
      IDX_STATUS:   rdata = {30'd0, done, busy};
      default:      rdata = '0;
    endcase
  end

  // Byte-masked register writes and the DONE write-1-to-clear strobe
  always_comb begin
    wr_ctrl32    = byte_merge({30'd0, ctrl_irq_en, ctrl_en}, wbs_dat_i, wbs_sel_i);
    wr_mode32    = byte_merge(32'(mode_req), wbs_dat_i, wbs_sel_i);
    wr_out32     = byte_merge(32'(out_reg), wbs_dat_i, wbs_sel_i);
    nxt_en       = ctrl_en;
    nxt_irq_en   = 1'b0;
    nxt_mode_req = mode_req;
    nxt_out_reg  = out_reg;
    clr_done     = 1'b0;
`ifdef ANALOG_IO_SEQ_IRQ_EN
    nxt_irq_en   = ctrl_irq_en;
`endif
    if (wb_wr) begin
      unique case (idx)
        IDX_CTRL: begin
          nxt_en = wr_ctrl32[0];
`ifdef ANALOG_IO_SEQ_IRQ_EN
          nxt_irq_en = wr_ctrl32[1];
`endif
        end
        IDX_MODE_REQ: nxt_mode_req = wr_mode32[MW-1:0];
        IDX_OUT:      nxt_out_reg  = wr_out32[NUM_PADS-1:0];
        IDX_STATUS:   clr_done     = wbs_sel_i[0] & wbs_dat_i[1];
        default: ;
      endcase
    end
  end

  // Wishbone slave registers: single-cycle ack, registered read data
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wbs_ack_o   <= 1'b0;
      wbs_dat_o   <= '0;
      ctrl_en     <= 1'b0;
      ctrl_irq_en <= 1'b0;
      mode_req    <= '0;
      out_reg     <= '0;
    end else begin
      wbs_ack_o   <= wb_req;
      wbs_dat_o   <= (wb_req && !wbs_we_i) ? rdata : '0;
      ctrl_en     <= nxt_en;
      ctrl_irq_en <= nxt_irq_en;
      mode_req    <= nxt_mode_req;
      out_reg     <= nxt_out_reg;
    end
  end

  // Per-pad difference between requested and current 2-bit mode fields
  always_comb begin
    diff_mask = '0;
    for (int unsigned i = 0; i < NUM_PADS; i++) begin
      diff_mask[i] = (mode_req[2*i +: 2] != mode_cur[2*i +: 2]);
    end
  end

  // Sequencer next state: IDLE -> GUARD (changed pads hi-Z) -> MAKE (apply)
  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    nxt_cur   = mode_cur;
    nxt_pend  = mode_pend;
    nxt_chg   = chg;
    set_done  = 1'b0;
    if (!ctrl_en) begin
      nxt_state = S_IDLE;
      nxt_cnt   = '0;
      nxt_cur   = '0;
      nxt_chg   = '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (mode_req != mode_cur) begin
            nxt_pend  = mode_req;
            nxt_chg   = diff_mask;
            nxt_cnt   = CNT_LOAD;
            nxt_state = S_GUARD;
          end
        end
        S_GUARD: begin
          if (cnt == '0) begin
            nxt_state = S_MAKE;
          end else begin
            nxt_cnt = cnt - 1'b1;
          end
        end
        S_MAKE: begin
          nxt_cur   = mode_pend;
          nxt_chg   = '0;
          set_done  = 1'b1;
          nxt_state = S_IDLE;
        end
        default: nxt_state = S_IDLE;
      endcase
    end
    nxt_done = set_done | (done & ~clr_done);
  end

  // Pad drive decode from the post-edge mode and guard mask; reserved mode
  // 11 decodes as hi-Z
  always_comb begin
    nxt_oeb     = '1;
    nxt_pad_out = '0;
    nxt_ana     = '0;
    for (int unsigned i = 0; i < NUM_PADS; i++) begin
      logic [1:0] m;
      m = nxt_chg[i] ? 2'b00 : nxt_cur[2*i +: 2];
      nxt_oeb[i]     = (m != 2'b01);
      nxt_pad_out[i] = (m == 2'b01) & out_reg[i];
      nxt_ana[i]     = (m == 2'b10);
    end
  end

  // Sequencer state and registered pad/status outputs
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state     <= S_IDLE;
      cnt       <= '0;
      mode_cur  <= '0;
      mode_pend <= '0;
      chg       <= '0;
      done      <= 1'b0;
      pad_oeb   <= '1;
      pad_out   <= '0;
      ana_en    <= '0;
      busy      <= 1'b0;
      irq       <= 1'b0;
    end else begin
      state     <= nxt_state;
      cnt       <= nxt_cnt;
      mode_cur  <= nxt_cur;
      mode_pend <= nxt_pend;
      chg       <= nxt_chg;
      done      <= nxt_done;
      pad_oeb   <= nxt_oeb;
      pad_out   <= nxt_pad_out;
      ana_en    <= nxt_ana;
      busy      <= (nxt_state != S_IDLE);
      irq       <= nxt_done & nxt_irq_en;
    end
  end

  assign unused_bits = &{1'b0, offset[1:0], wr_ctrl32, wr_mode32, wr_out32};

endmodule

// File: tb/tb_analog_io_sequencer.sv
// Self-checking bench for analog_io_sequencer (NUM_PADS=6, GUARD_CYCLES=4).
// Register reads go through a queue of expected values popped on ack.
module tb_analog_io_sequencer;

  localparam int unsigned NP = 6;
  localparam int unsigned G  = 4;
  localparam logic [31:0] BASE   = 32'h3000_0000;
  localparam logic [31:0] A_CTRL = BASE + 32'h00;
  localparam logic [31:0] A_MODE = BASE + 32'h04;
  localparam logic [31:0] A_OUT  = BASE + 32'h08;
  localparam logic [31:0] A_CUR  = BASE + 32'h0C;
  localparam logic [31:0] A_STAT = BASE + 32'h10;
`ifdef ANALOG_IO_SEQ_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          cyc, stb, we;
  logic [3:0]    sel;
  logic [31:0]   adr, dat;
  logic          ack;
  logic [31:0]   dat_o;
  logic [NP-1:0] pad_oeb, pad_out, ana_en;
  logic          busy, irq;

  int n_total = 0;
  int n_bad   = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t exp_q[$];

  analog_io_sequencer #(
    .NUM_PADS    (NP),
    .GUARD_CYCLES(G),
    .BASE_ADDR   (BASE)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .wbs_cyc_i(cyc),
    .wbs_stb_i(stb),
    .wbs_we_i (we),
    .wbs_sel_i(sel),
    .wbs_adr_i(adr),
    .wbs_dat_i(dat),
    .wbs_ack_o(ack),
    .wbs_dat_o(dat_o),
    .pad_oeb  (pad_oeb),
    .pad_out  (pad_out),
    .ana_en   (ana_en),
    .busy     (busy),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; the request is sampled at the next posedge and the
  // task returns at the negedge on which ack is seen.
  task automatic wb_cycle(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, output logic [31:0] rd, output bit ok);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat = d; sel = s;
    ok = 1'b0;
    rd = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ack) begin
        ok = 1'b1;
        rd = dat_o;
        break;
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0;
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s = 4'hF);
    logic [31:0] rd;
    bit ok;
    wb_cycle(1'b1, a, d, s, rd, ok);
    if (!ok) check("write_ack", 32'd0, 32'd1);
  endtask

  task automatic wb_read(input logic [31:0] a, input logic [31:0] e, input string tag);
    logic [31:0] rd;
    bit ok;
    exp_t x;
    exp_q.push_back('{tag: tag, val: e});
    wb_cycle(1'b0, a, 32'd0, 4'hF, rd, ok);
    x = exp_q.pop_front();
    if (ok) check(x.tag, rd, x.val);
    else    check({x.tag, "_ack"}, 32'd0, 32'd1);
  endtask

  task automatic check_pads(input string tag, input logic [NP-1:0] e_oeb,
                            input logic [NP-1:0] e_out, input logic [NP-1:0] e_ana);
    check({tag, "_oeb"}, 32'(pad_oeb), 32'(e_oeb));
    check({tag, "_out"}, 32'(pad_out), 32'(e_out));
    check({tag, "_ana"}, 32'(ana_en), 32'(e_ana));
    check({tag, "_bbm"}, 32'(~pad_oeb & ana_en), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; adr = '0; dat = '0;
    tick(2);
    check_pads("rst_hold", '1, '0, '0);
    rst = 1'b0;
    tick(1);
    check_pads("reset", '1, '0, '0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_irq", 32'(irq), 32'd0);
    check("reset_ack", 32'(ack), 32'd0);
    check("reset_dat", dat_o, 32'd0);
    wb_read(A_CTRL, 32'd0, "rst_ctrl");
    wb_read(A_MODE, 32'd0, "rst_mode_req");
    wb_read(A_OUT,  32'd0, "rst_out");
    wb_read(A_CUR,  32'd0, "rst_mode_cur");
    wb_read(A_STAT, 32'd0, "rst_status");

    // hi-Z -> digital on pad0
    wb_write(A_CTRL, 32'd1);
    wb_write(A_OUT, 32'd1);
    wb_write(A_MODE, 32'h001);
    for (int n = 1; n <= G + 3; n++) begin
      tick(1);
      check("dig_busy", 32'(busy), 32'(n <= G + 1));
      if (n >= G + 2) check_pads("dig_on", 6'b111110, 6'b000001, '0);
      else            check_pads("dig_guard", '1, '0, '0);
    end
    // digital -> analog on pad0
    wb_write(A_MODE, 32'h002);
    for (int n = 1; n <= G + 3; n++) begin
      tick(1);
      check("ana_busy", 32'(busy), 32'(n <= G + 1));
      check_pads("ana", '1, '0, (n >= G + 2) ? 6'b000001 : 6'b000000);
    end
    wb_read(A_STAT, 32'h2, "done_set");
    wb_write(A_STAT, 32'h2);
    wb_read(A_STAT, 32'h0, "done_clr");

    // Pads 0/1 steady in 01/10 while pad2 changes
    wb_write(A_MODE, 32'h009);
    tick(G + 3);
    wb_read(A_CUR, 32'h009, "cur_009");
    wb_write(A_MODE, 32'h029);
    for (int n = 1; n <= G + 3; n++) begin
      tick(1);
      check_pads("steady", 6'b111110, 6'b000001, (n >= G + 2) ? 6'b000110 : 6'b000010);
    end
    wb_read(A_CUR, 32'h029, "cur_029");

    // OUT-only change: follows one clock after the write edge, no sequence
    wb_write(A_OUT, 32'd0);
    check("out_hold", 32'(pad_out), 32'h1);
    tick(1);
    check("out_follow", 32'(pad_out), 32'h0);
    check("out_nobusy", 32'(busy), 32'd0);
    wb_write(A_OUT, 32'd1);
    tick(1);

    // MODE_REQ rewritten mid-GUARD: first sequence completes, second follows
    wb_write(A_MODE, 32'h001);
    tick(1);
    wb_write(A_MODE, 32'h005);
    for (int n = 3; n <= 2 * G + 5; n++) begin
      tick(1);
      check("chain_busy", 32'(busy),
            32'((n <= G + 1) || (n >= G + 3 && n <= 2 * G + 3)));
      check_pads("chain", (n >= 2 * G + 4) ? 6'b111100 : 6'b111110, 6'b000001, '0);
    end
    wb_read(A_CUR, 32'h005, "cur_005");
    wb_read(A_STAT, 32'h2, "chain_done");
    wb_write(A_STAT, 32'h2);

    // Interrupt path
    wb_write(A_CTRL, 32'd3);
    wb_write(A_MODE, 32'h002);
    tick(G + 2);
    check("irq_set", 32'(irq), 32'(IRQ_ON));
    wb_read(A_CTRL, IRQ_ON ? 32'd3 : 32'd1, "ctrl_rd");
    wb_write(A_STAT, 32'h2);
    tick(1);
    check("irq_clr", 32'(irq), 32'd0);
    wb_read(A_STAT, 32'h0, "stat_clr");

    // Disable mid-GUARD
    wb_write(A_MODE, 32'h001);
    tick(1);
    check("dis_busy_pre", 32'(busy), 32'd1);
    wb_write(A_CTRL, 32'd0);
    tick(1);
    check_pads("disable", '1, '0, '0);
    check("dis_busy", 32'(busy), 32'd0);
    wb_read(A_CUR, 32'h0, "dis_cur");

    // Async reset mid-GUARD
    wb_write(A_MODE, 32'h009);
    wb_write(A_CTRL, 32'd1);
    tick(G + 2);
    check_pads("pre_rst", 6'b111110, 6'b000001, 6'b000010);
    wb_write(A_MODE, 32'h029);
    tick(2);
    check("pre_rst_busy", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_pads("async_rst", '1, '0, '0);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_irq", 32'(irq), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    wb_read(BASE + 32'h20, 32'h0, "unmapped");
    wb_read(A_CUR,  32'h0, "post_rst_cur");
    wb_read(A_CTRL, 32'h0, "post_rst_ctrl");
    wb_read(A_MODE, 32'h0, "post_rst_req");

    // Byte enables
    wb_write(A_OUT, 32'hFF, 4'h0);
    wb_read(A_OUT, 32'h0, "sel_none");
    wb_write(A_MODE, 32'hFFF, 4'h2);
    wb_read(A_MODE, 32'hF00, "sel_byte1");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/analog_io_sequencer.md
# analog_io_sequencer

Wishbone-configurable pad-mode controller for the analog user pads, replacing the fixed io_oeb tie-off block. Each of NUM_PADS pads is independently set to hi-Z, digital output or analog (pad tri-stated, analog switch/opamp enable asserted). Mode changes run break-before-make: every pad whose mode changes is forced hi-Z for a programmable guard interval before the new mode is applied. It sits in user_project_wrapper on the Wishbone slave bus. It drives io_oeb/io_out for the analog pads and the enables of the analog macros.

## Interface
- NUM_PADS, 6, pad channel count, 1..16
- GUARD_CYCLES, 16, break-before-make hi-Z interval in clocks, ≥1
- BASE_ADDR, 32'h3000_0000, Wishbone base address, word aligned
- wb_clk_i  input  1  clock; all logic on rising edge
- wb_rst_i  input  1  asynchronous active-high reset
- wbs_cyc_i, wbs_stb_i, wbs_we_i  input  1 each  Wishbone classic cycle, strobe, write
- wbs_sel_i  input  4  write byte enables
- wbs_adr_i  input  32  byte address
- wbs_dat_i  input  32  write data
- wbs_ack_o  output  1  transfer acknowledge
- wbs_dat_o  output  32  read data
- pad_oeb  output  NUM_PADS  pad output-enable, active low
- pad_out  output  NUM_PADS  pad drive value
- ana_en  output  NUM_PADS  analog path enable per pad
- busy  output  1  sequence in progress
- irq  output  1  sequence-done interrupt, level

## Operation
- Registers at word offsets from BASE_ADDR:
  - 0x00 CTRL, RW: bit0 EN, bit1 IRQ_EN.
  - 0x04 MODE_REQ, RW: 2 bits per pad, pad i at [2i+1:2i].
  - 0x08 OUT, RW: bit i drive for pad i.
  - 0x0C MODE_CUR, RO.
  - 0x10 STATUS: bit0 busy (RO), bit1 DONE (sticky, write 1 to clear).
- Unused bits read 0. Other addresses are acked, read 0, and writes are ignored. Writes honour wbs_sel_i per byte.
- Mode encoding:
  - 00 hi-Z: oeb=1, ana_en=0.
  - 01 digital out: oeb=0, pad_out=OUT[i].
  - 10 analog: oeb=1, ana_en=1.
  - 11 reserved, treated as 00.
  - pad_out=0 whenever a pad is not in mode 01.
- FSM states:
  - IDLE: if EN=1 and MODE_REQ≠MODE_CUR, capture MODE_PEND=MODE_REQ and the change mask CHG (pads whose 2-bit field differs), then go to GUARD.
  - GUARD: pads in CHG forced hi-Z; counter loaded GUARD_CYCLES-1 and decremented each clock; at 0 go to MAKE.
  - MAKE: MODE_CUR←MODE_PEND, CHG←0, DONE←1, go to IDLE.
- Pads not in CHG keep their current mode and OUT tracking throughout.
- MODE_REQ writes while busy are stored, but the active sequence completes with MODE_PEND. IDLE re-evaluates on the next clock and starts a new sequence if MODE_REQ≠MODE_CUR.
- OUT-only changes are not mode changes and need no sequence: pad_out follows OUT one clock after the write.
- EN 1→0: all outputs go hi-Z/ana_en=0 on the next edge, FSM goes to IDLE, MODE_CUR←0, CHG←0, DONE unchanged.
- irq = DONE & IRQ_EN.
- DONE set and a W1C in the same cycle: set wins.

## Timing
- Reset values:
  - wbs_ack_o=0, wbs_dat_o=0.
  - pad_oeb all 1, pad_out 0, ana_en 0.
  - busy=0, irq=0.
  - CTRL, MODE_REQ, OUT, MODE_CUR, DONE all 0; FSM in IDLE.
- Wishbone:
  - cyc&stb sampled at edge k → ack high for exactly one cycle after k; write data registered at edge k.
  - Back-to-back strobes ack every other cycle (ack deasserts between).
  - Read data is valid while ack is high.
- Sequence timing (MODE_REQ write at edge T0, EN=1):
  - FSM enters GUARD at T0+1; changed pads hi-Z from T0+1.
  - busy=1 from T0+1 through T0+GUARD_CYCLES+1.
  - New modes appear on outputs from T0+GUARD_CYCLES+2; DONE/irq set at the same edge.
- All outputs are registered; there is no combinational path from the Wishbone inputs to the pad outputs.
- Reset asserted mid-sequence: all outputs go to reset values immediately (asynchronous); no partial mode survives.

## Configuration
- ANALOG_IO_SEQ_IRQ_EN defined: irq output and CTRL.IRQ_EN are implemented as above.
- Undefined: irq tied 0, CTRL bit1 reads 0 and ignores writes; DONE still implemented and readable.

## Test plan
- Reset, then read all registers → all 0; pad_oeb=6'h3F, ana_en=0, pad_out=0, irq=0.
- GUARD_CYCLES=4; CTRL=1, MODE_REQ=0x001 (pad0 digital), OUT=1 → pad0 oeb=0/out=1 at T0+6, busy high 5 cycles; then MODE_REQ=0x002 → pad0 oeb=1/out=0 at T0+1, ana_en[0]=1 at T0+6, never oeb=0 together with ana_en=1.
- Pads 0/1 steady in modes 01/10, change pad2 only → pads 0/1 outputs constant every cycle, MODE_CUR=0x029 at end.
- Write MODE_REQ 0x005 mid-GUARD of a 0x001 sequence → first sequence ends MODE_CUR=0x001, second starts next cycle, ends MODE_CUR=0x005, DONE set.
- CTRL=3, complete sequence → irq=1; write STATUS=0x2 → irq=0 next cycle; CTRL=0 mid-GUARD → all hi-Z next edge, MODE_CUR=0, busy=0.
- Assert wb_rst_i async mid-GUARD → outputs reset before next clock edge; read 0x20 → ack, data 0.
